// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake, illegal-opcode and memory-timeout traps, and a retired-instruction counter.
//
// state    | meaning
// S_FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
// S_DECODE | opcode legality check, branch target precompute
// S_EXEC   | ALU operation / branch / jump resolution
// S_MEM    | data memory access for lw/sw, wait for mem_ready
// S_WB     | register file write-back
// S_TRAP   | halted until reset, all strobes low
module multicycle_control_unit #(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic [1:0]          pc_source,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [CNT_W-1:0]    retired
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [1:0]          trap_cause_q, trap_cause_d;
   logic [CNT_W-1:0]    retired_q;
   logic                retire;
   logic                legal;
   logic                timeout;

   assign legal = (opcode == OP_R)    || (opcode == OP_LW)   || (opcode == OP_SW)  ||
                  (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_BEQ) ||
                  (opcode == OP_J)    || (opcode == OP_JAL);

   assign timeout = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         wait_cnt_q   <= '0;
         trap_cause_q <= 2'b00;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         trap_cause_q <= trap_cause_d;
         if (retire) retired_q <= retired_q + 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      trap_cause_d  = trap_cause_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = '0;
      // Strobes stay low for the whole reset cycle; the register reset overrides next state.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (timeout) begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'b10;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               if (legal) begin
                  state_d = S_EXEC;
               end else begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'b01;
               end
            end
            S_EXEC: begin
               alu_op = ALUOP_W'(opcode);
               case (opcode)
                  OP_R: begin
                     alu_src_a = 1'b1;
                     state_d   = S_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_src_a = 1'b1;
                     alu_src_b = 2'b10;
                     state_d   = S_MEM;
                  end
                  OP_ADDI, OP_ANDI: begin
                     alu_src_a = 1'b1;
                     alu_src_b = 2'b10;
                     state_d   = S_WB;
                  end
                  OP_BEQ: begin
                     alu_src_a     = 1'b1;
                     pc_write_cond = 1'b1;
                     pc_source     = 2'b01;
                     state_d       = S_FETCH;
                     retire        = 1'b1;
                  end
                  OP_J, OP_JAL: begin
                     pc_write  = 1'b1;
                     pc_source = 2'b10;
                     if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                     end
                     state_d = S_FETCH;
                     retire  = 1'b1;
                  end
                  // Opcode changed after DECODE: treat as illegal rather than guess.
                  default: begin
                     alu_op       = '0;
                     state_d      = S_TRAP;
                     trap_cause_d = 2'b01;
                  end
               endcase
            end
            S_MEM: begin
               i_or_d    = 1'b1;
               mem_read  = (opcode == OP_LW);
               mem_write = (opcode != OP_LW);
               if (mem_ready) begin
                  if (opcode == OP_LW) begin
                     state_d = S_WB;
                  end else begin
                     state_d = S_FETCH;
                     retire  = 1'b1;
                  end
               end else if (timeout) begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'b10;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            S_WB: begin
               reg_write = 1'b1;
               if (opcode == OP_R)       reg_dst    = 2'b01;
               else if (opcode == OP_LW) mem_to_reg = 2'b01;
               state_d = S_FETCH;
               retire  = 1'b1;
            end
            default: begin
               state_d = S_TRAP;
            end
         endcase
      end
   end

   assign trap       = (state_q == S_TRAP);
   assign trap_cause = trap_cause_q;
   assign retired    = retired_q;

endmodule
